// File: rtl/matrix_scanner.sv
// rtl/matrix_scanner.sv - 16x16 row-scanned seven-segment glyph display with blink and scroll
// Glyph/mode requests are latched and only take effect at a frame boundary.
module matrix_scanner #(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_DIV  = 32,
  parameter int SCROLL_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  glyph_sel,
  input  logic [1:0]  mode,
  input  logic        load,
  output logic [3:0]  row_bin,
  output logic [15:0] col,
  output logic        pending,
  output logic        frame_start
);

  localparam logic [15:0] PRESC_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_LAST  = 8'(BLINK_DIV - 1);
  localparam logic [7:0]  SCROLL_LAST = 8'(SCROLL_DIV - 1);
  localparam logic [1:0]  MODE_BLINK  = 2'd1;
  localparam logic [1:0]  MODE_SCROLL = 2'd2;
  localparam logic [15:0] BAR         = 16'h0FF0;
  localparam logic [15:0] LEFT_BIT    = 16'h0800;
  localparam logic [15:0] RIGHT_BIT   = 16'h0010;

  logic [15:0] presc_q, presc_d;
  logic [3:0]  row_q, row_d;
  logic        fs_q, fs_d;
  logic        pend_q, pend_d;
  logic [3:0]  pend_glyph_q, pend_glyph_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic [3:0]  glyph_q, glyph_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic [7:0]  scroll_cnt_q, scroll_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  offset_q, offset_d;

  logic        tick;
  logic        boundary;
  logic        apply;

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (row_q == 4'd15);
  assign apply    = boundary && (pend_q || load);

  always_comb begin
    presc_d      = tick ? 16'd0 : presc_q + 16'd1;
    row_d        = tick ? row_q + 4'd1 : row_q;
    fs_d         = boundary;
    pend_d       = pend_q;
    pend_glyph_d = pend_glyph_q;
    pend_mode_d  = pend_mode_q;
    glyph_d      = glyph_q;
    mode_d       = mode_q;
    blink_cnt_d  = blink_cnt_q;
    scroll_cnt_d = scroll_cnt_q;
    phase_d      = phase_q;
    offset_d     = offset_q;

    if (load && !boundary) begin
      pend_d       = 1'b1;
      pend_glyph_d = glyph_sel;
      pend_mode_d  = mode;
    end

    if (boundary) begin
      pend_d = 1'b0;
      if (apply) begin
        // A load arriving in the boundary cycle is newer than anything pending.
        glyph_d      = load ? glyph_sel : pend_glyph_q;
        mode_d       = load ? mode : pend_mode_q;
        blink_cnt_d  = 8'd0;
        scroll_cnt_d = 8'd0;
        phase_d      = 1'b0;
        offset_d     = 4'd0;
      end else begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = 8'd0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
        if (scroll_cnt_q == SCROLL_LAST) begin
          scroll_cnt_d = 8'd0;
          offset_d     = offset_q + 4'd1;
        end else begin
          scroll_cnt_d = scroll_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= 16'd0;
      row_q        <= 4'd0;
      fs_q         <= 1'b0;
      pend_q       <= 1'b0;
      pend_glyph_q <= 4'd0;
      pend_mode_q  <= 2'd0;
      glyph_q      <= 4'd15;
      mode_q       <= 2'd0;
      blink_cnt_q  <= 8'd0;
      scroll_cnt_q <= 8'd0;
      phase_q      <= 1'b0;
      offset_q     <= 4'd0;
    end else begin
      presc_q      <= presc_d;
      row_q        <= row_d;
      fs_q         <= fs_d;
      pend_q       <= pend_d;
      pend_glyph_q <= pend_glyph_d;
      pend_mode_q  <= pend_mode_d;
      glyph_q      <= glyph_d;
      mode_q       <= mode_d;
      blink_cnt_q  <= blink_cnt_d;
      scroll_cnt_q <= scroll_cnt_d;
      phase_q      <= phase_d;
      offset_q     <= offset_d;
    end
  end

  // Segment set as {a,b,c,d,e,f,g}; codes above 9 are blank.
  function automatic logic [6:0] segs_of(input logic [3:0] code);
    case (code)
      4'd0:    segs_of = 7'b1111110;
      4'd1:    segs_of = 7'b0110000;
      4'd2:    segs_of = 7'b1101101;
      4'd3:    segs_of = 7'b1111001;
      4'd4:    segs_of = 7'b0110011;
      4'd5:    segs_of = 7'b1011011;
      4'd6:    segs_of = 7'b1011111;
      4'd7:    segs_of = 7'b1110000;
      4'd8:    segs_of = 7'b1111111;
      4'd9:    segs_of = 7'b1111011;
      default: segs_of = 7'b0000000;
    endcase
  endfunction

  logic [6:0]  seg;
  logic [15:0] base_row;
  logic [31:0] rot_wide;

  always_comb begin
    seg      = segs_of(glyph_q);
    base_row = 16'h0000;
    if (row_q >= 4'd1 && row_q <= 4'd7) begin
      if (seg[1]) base_row = base_row | LEFT_BIT;   // f
      if (seg[5]) base_row = base_row | RIGHT_BIT;  // b
    end
    if (row_q >= 4'd7 && row_q <= 4'd13) begin
      if (seg[2]) base_row = base_row | LEFT_BIT;   // e
      if (seg[4]) base_row = base_row | RIGHT_BIT;  // c
    end
    if (row_q == 4'd1  && seg[6]) base_row = base_row | BAR;
    if (row_q == 4'd7  && seg[0]) base_row = base_row | BAR;
    if (row_q == 4'd13 && seg[3]) base_row = base_row | BAR;

    // Upper half of the doubled word is the left rotation.
    rot_wide = {base_row, base_row} << offset_q;

    case (mode_q)
      MODE_BLINK:  col = phase_q ? 16'h0000 : base_row;
      MODE_SCROLL: col = rot_wide[31:16];
      default:     col = base_row;
    endcase
  end

  assign row_bin     = row_q;
  assign pending     = pend_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scanner.sv
// tb/tb_matrix_scanner.sv - directed, table-driven and random checks of matrix_scanner
module tb_matrix_scanner;

  localparam int SD    = 2;
  localparam int BD    = 2;
  localparam int SCD   = 1;
  localparam int FRAME = 16 * SD;

  // Segment geometry in order a,b,c,d,e,f,g: row span and column span.
  localparam int RLO [7] = '{1, 1, 7, 13, 7, 1, 7};
  localparam int RHI [7] = '{1, 7, 13, 13, 13, 7, 7};
  localparam int CLO [7] = '{4, 4, 4, 4, 11, 11, 4};
  localparam int CHI [7] = '{11, 4, 4, 11, 11, 11, 11};
  localparam logic [6:0] SEGS [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                       7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  logic        clk;
  logic        rst;
  logic [3:0]  glyph_sel;
  logic [1:0]  mode;
  logic        load;
  logic [3:0]  row_bin;
  logic [15:0] col;
  logic        pending;
  logic        frame_start;

  matrix_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD), .SCROLL_DIV(SCD)) dut (
    .clk(clk), .rst(rst), .glyph_sel(glyph_sel), .mode(mode), .load(load),
    .row_bin(row_bin), .col(col), .pending(pending), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int k;
  bit m_pend;
  int m_pg, m_pm, m_g, m_m, m_frames;

  typedef struct {
    int g;
    int m;
    int row;
    logic [15:0] exp_col;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] glyph_row(input int g, input int r);
    logic [15:0] v;
    logic [6:0]  s;
    v = '0;
    if (g > 9) return v;
    s = SEGS[g];
    for (int i = 0; i < 7; i++)
      if (s[6-i] && r >= RLO[i] && r <= RHI[i])
        for (int c = CLO[i]; c <= CHI[i]; c++) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] exp_col();
    logic [15:0] v;
    int n;
    v = glyph_row(m_g, (k / SD) % 16);
    if (m_m == 1 && ((m_frames / BD) % 2) == 1) return 16'h0000;
    if (m_m == 2) begin
      n = (m_frames / SCD) % 16;
      for (int i = 0; i < n; i++) v = {v[14:0], v[15]};
    end
    return v;
  endfunction

  task automatic check_model();
    chk("row_bin", row_bin, (k / SD) % 16);
    chk("frame_start", frame_start, (k > 0 && (k % FRAME) == 0) ? 1 : 0);
    chk("pending", pending, m_pend);
    chk("col", col, exp_col());
  endtask

  task automatic step();
    bit bnd;
    bnd = (k % FRAME) == FRAME - 1;
    if (bnd) begin
      if (load) begin
        m_g = glyph_sel; m_m = mode; m_frames = 0;
      end else if (m_pend) begin
        m_g = m_pg; m_m = m_pm; m_frames = 0;
      end else begin
        m_frames++;
      end
      m_pend = 0;
    end else if (load) begin
      m_pend = 1; m_pg = glyph_sel; m_pm = mode;
    end
    @(posedge clk);
    k++;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_load(input int g, input int m);
    glyph_sel = 4'(g);
    mode      = 2'(m);
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic advance_to(input int pos);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != pos; i++) step();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_row", row_bin, 0);
    chk("rst_col", col, 0);
    chk("rst_pending", pending, 0);
    chk("rst_fs", frame_start, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_row", row_bin, 0);
    chk("rst_hold_col", col, 0);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    k = 0; m_pend = 0; m_pg = 0; m_pm = 0; m_g = 15; m_m = 0; m_frames = 0;
  endtask

  vec_t vecs [12];
  logic [15:0] g5_rows [16];
  int hits;

  initial begin
    clk = 1'b0; rst = 1'b1; load = 1'b0; glyph_sel = '0; mode = '0;
    vecs[0]  = '{0, 0, 7, 16'h0810};
    vecs[1]  = '{1, 0, 1, 16'h0010};
    vecs[2]  = '{2, 0, 7, 16'h0FF0};
    vecs[3]  = '{3, 0, 13, 16'h0FF0};
    vecs[4]  = '{4, 0, 1, 16'h0810};
    vecs[5]  = '{4, 0, 13, 16'h0010};
    vecs[6]  = '{6, 0, 3, 16'h0800};
    vecs[7]  = '{9, 0, 10, 16'h0010};
    vecs[8]  = '{12, 0, 7, 16'h0000};
    vecs[9]  = '{2, 3, 7, 16'h0FF0};
    vecs[10] = '{4, 1, 1, 16'h0810};
    vecs[11] = '{7, 2, 1, 16'h0FF0};
    g5_rows = '{16'h0000, 16'h0FF0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0FF0,
                16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0FF0, 16'h0000, 16'h0000};

    @(negedge clk);
    do_reset();

    // Reset mid-scan, then rows step every SD cycles.
    repeat (37) step();
    do_reset();
    step(); step();
    chk("row_after_rst_2", row_bin, 1);
    step(); step();
    chk("row_after_rst_4", row_bin, 2);

    // Glyph 5 loaded at row 3 waits for the boundary.
    advance_to(3 * SD);
    do_load(5, 0);
    chk("pend_after_load", pending, 1);
    advance_to(0);
    chk("g5_fs", frame_start, 1);
    chk("g5_pend_clr", pending, 0);
    for (int r = 0; r < 16; r++) begin
      advance_to(r * SD);
      chk($sformatf("g5_row%0d", r), col, g5_rows[r]);
    end

    // Last load wins; glyph 1 never shows.
    advance_to(4 * SD);
    do_load(1, 0);
    advance_to(9 * SD);
    do_load(8, 0);
    advance_to(0);
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (col == 16'h0010) hits++;
      step();
    end
    chk("no_glyph1_rows", hits, 0);
    advance_to(SD);
    chk("g8_row1", col, 16'h0FF0);

    // Load in the boundary cycle applies immediately.
    advance_to(FRAME - 1);
    do_load(3, 0);
    chk("bnd_load_pend", pending, 0);
    chk("bnd_load_fs", frame_start, 1);
    advance_to(13 * SD);
    chk("bnd_load_g3_row13", col, 16'h0FF0);

    // Scroll glyph 8 one column per frame.
    advance_to(5 * SD);
    do_load(8, 2);
    advance_to(0);
    for (int f = 0; f <= 16; f++) begin
      advance_to(SD);
      if (f == 0 || f == 16) chk($sformatf("scroll_f%0d", f), col, 16'h0FF0);
      else if (f == 1) chk("scroll_f1", col, 16'h1FE0);
      step();
    end

    // Blink glyph 0: two frames lit, two dark.
    advance_to(5 * SD);
    do_load(0, 1);
    advance_to(0);
    for (int f = 0; f < 6; f++) begin
      advance_to(SD);
      chk($sformatf("blink_f%0d", f), col, ((f % 4) < 2) ? 16'h0FF0 : 16'h0000);
      step();
    end

    // Table of glyph/mode/row vectors, each checked in the first frame after apply.
    for (int i = 0; i < 12; i++) begin
      advance_to(6 * SD);
      do_load(vecs[i].g, vecs[i].m);
      advance_to(0);
      advance_to(vecs[i].row * SD);
      chk($sformatf("vec%0d", i), col, vecs[i].exp_col);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else if ($urandom_range(0, 99) < 4) do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
